aes_round_sequencer: RTL
========================

# aes_round_sequencer

Iterative AES-128 encryption controller that sequences one shared round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) over 10 rounds, one round per clock. It sits between the block-input interface and the key schedule. It accepts a 128-bit plaintext block over a valid/ready handshake, requests round keys by index, bypasses MixColumns on the final round, and presents the ciphertext over a valid/ready handshake.

## Interface
- NR, 10: number of rounds. Fixed for AES-128; other values unsupported.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  plaintext block valid.
- in_ready  out  1  block can be accepted this cycle.
- in_data  in  128  plaintext. Byte index b = 4*row + col, at bits [8*b+7:8*b].
- rk_idx  out  4  round-key index requested this cycle, 0..10.
- rk_data  in  128  round key for rk_idx, combinational same cycle, same byte layout.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext, same byte layout.
- busy  out  1  high in any state other than IDLE.
- round  out  4  current round number; 0 when not in RUN.

## Operation
- Reset values: state IDLE, round counter 0, state register 0, out_valid 0, out_data 0, busy 0, in_ready 0 during reset and 1 the first cycle after.
- FSM states:
  - IDLE: in_ready=1 and rk_idx=0. On in_valid, the state register loads in_data ^ rk_data, round<=1, and the FSM goes to RUN.
  - RUN: rk_idx=round. For rounds 1..NR-1: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_data, then round++.
  - RUN, round NR: the MixColumns output is bypassed. The result goes to DONE (or as described under Configuration).
  - DONE: out_valid=1 and out_data=state. When out_valid && out_ready, the FSM goes to IDLE and round<=0.
- in_ready is 0 in RUN and DONE. in_valid is ignored there, and in_data does not need to be held.
- out_data must be stable while out_valid=1 && out_ready=0.
- The round counter never exceeds NR and never wraps. An illegal state encoding returns to IDLE.
- Reset mid-operation aborts the block silently, and no output is produced.

## Timing
- Accept edge at cycle T. Rounds 1..10 execute at cycles T+1..T+10.
- out_valid rises at T+11, so latency is 11 cycles accept-to-valid.
- With out_ready held high, out_valid lasts 1 cycle and in_ready returns at T+12. Maximum throughput is 1 block per 12 cycles.
- rk_idx is registered-state-derived only (no combinational path from in_valid). rk_data is sampled on the same edge it is used.

## Configuration
- AES_OUT_REG_EN defined:
  - Adds a separate output register with its own valid bit. On completing round NR, the result moves to the output register if it is empty or being drained that cycle, and the FSM goes straight to IDLE.
  - If the output register is full and not draining, the FSM enters HOLD. HOLD keeps the state register and rk_idx=NR, and moves the result to the output register on the first cycle it empties.
  - Back-to-back throughput is 1 block per 11 cycles. Latency is unchanged.
- AES_OUT_REG_EN undefined: there is no HOLD state and no output register, and behaviour is exactly as described above.

## Structure
- Shared package aes_pkg holds:
  - the state encoding type (IDLE, RUN, DONE, HOLD);
  - AES_NR=10;
  - the block width 128;
  - the byte-index helper constants.
- The combinational datapath is one sub-module, aes_round_dp. It instantiates the existing SubBytes, ShiftRows and MixColumns modules plus a last-round bypass input. The sequencer holds only the FSM, counter and registers.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff. The bench model supplies rk_data per rk_idx, and the bench packs FIPS byte n at b = 4*(n%4) + n/4. Required: out_valid at T+11 with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734. Required ciphertext 3925841d02dc09fbdc118597196a0b32. rk_idx must step 0,1,..,10 on consecutive cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Required: out_data stable, in_ready=0, busy=1. Raise out_ready; one cycle later in_ready=1.
- in_valid toggled during RUN with random in_data: no effect on the ciphertext, and round increments 1..10.
- rst_n=0 for one cycle at round 5: required next cycle state IDLE, round=0, out_valid=0, and the following block encrypts correctly.
- With AES_OUT_REG_EN: two back-to-back blocks with out_ready=0. The second must wait in HOLD. Release out_ready: both ciphertexts appear in order, with the second valid the cycle after the first is consumed.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte helpers for the round sequencer and its datapath.
package aes_pkg;

   localparam int AES_NR     = 10;
   localparam int AES_BW     = 128;
   localparam int AES_NB     = 16;
   localparam int AES_BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_HOLD = 2'd3
   } aes_state_e;

   typedef logic [AES_BW-1:0] aes_block_t;

   // Byte (row, col) lives at bits [8*(4*row+col) +: 8].
   function automatic int byte_lsb(input int row, input int col);
      return AES_BYTE_W * (4 * row + col);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 by repeated squaring, then the FIPS-197 affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in, round-key and ciphertext-out signals of the AES round sequencer.
// slave is the sequencer side; master is the surrounding system.
interface aes_round_sequencer_if;

   logic               in_valid;
   logic               in_ready;
   aes_pkg::aes_block_t in_data;
   logic [3:0]         rk_idx;
   aes_pkg::aes_block_t rk_data;
   logic               out_valid;
   logic               out_ready;
   aes_pkg::aes_block_t out_data;
   logic               busy;
   logic [3:0]         round;

   modport master (
      output in_valid, in_data, rk_data, out_ready,
      input  in_ready, rk_idx, out_valid, out_data, busy, round
   );

   modport slave (
      input  in_valid, in_data, rk_data, out_ready,
      output in_ready, rk_idx, out_valid, out_data, busy, round
   );

endinterface

// File: rtl/aes_mix_columns.sv
// MixColumns: each column multiplied by the circulant {02,03,01,01}; combinational.
module aes_mix_columns
   import aes_pkg::*;
(
   input  aes_block_t data_i,
   output aes_block_t data_o
);

   logic [7:0] a [4];

   always_comb begin
      data_o = '0;
      a      = '{default: 8'h00};
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            a[r] = data_i[byte_lsb(r, c) +: 8];
         end
         for (int r = 0; r < 4; r++) begin
            data_o[byte_lsb(r, c) +: 8] = xtime(a[r]) ^ xtime(a[(r + 1) % 4]) ^ a[(r + 1) % 4]
                                         ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
         end
      end
   end

endmodule

// File: rtl/aes_round_dp.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (bypassed when last_i), AddRoundKey.
module aes_round_dp
   import aes_pkg::*;
(
   input  aes_block_t state_i,
   input  aes_block_t rk_i,
   input  logic       last_i,
   output aes_block_t state_o
);

   aes_block_t sb;
   aes_block_t sr;
   aes_block_t mc;

   aes_sub_bytes   u_sub   (.data_i(state_i), .data_o(sb));
   aes_shift_rows  u_shift (.data_i(sb),      .data_o(sr));
   aes_mix_columns u_mix   (.data_i(sr),      .data_o(mc));

   assign state_o = (last_i ? sr : mc) ^ rk_i;

endmodule

// File: rtl/aes_shift_rows.sv
// ShiftRows: row r rotates left by r byte positions; combinational.
module aes_shift_rows
   import aes_pkg::*;
(
   input  aes_block_t data_i,
   output aes_block_t data_o
);

   always_comb begin
      data_o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            data_o[byte_lsb(r, c) +: 8] = data_i[byte_lsb(r, (c + r) % 4) +: 8];
         end
      end
   end

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes over all 16 state bytes; combinational.
module aes_sub_bytes
   import aes_pkg::*;
(
   input  aes_block_t data_i,
   output aes_block_t data_o
);

   always_comb begin
      data_o = '0;
      for (int b = 0; b < AES_NB; b++) begin
         data_o[8*b +: 8] = sbox(data_i[8*b +: 8]);
      end
   end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128: one round per clock, ciphertext valid 11 cycles after accept, held under backpressure.
// AES_OUT_REG_EN adds a decoupled output register (HOLD state when full) for 11-cycle throughput.
module aes_round_sequencer
   import aes_pkg::*;
(
   input logic                  clk,
   input logic                  rst_n,
   aes_round_sequencer_if.slave aes_if
);

   aes_state_e state_q, state_d;
   logic [3:0] round_q, round_d;
   aes_block_t blk_q, blk_d;
   aes_block_t dp_out;
   logic       last_round;

`ifdef AES_OUT_REG_EN
   aes_block_t oreg_q, oreg_d;
   logic       ovld_q, ovld_d;
   logic       oreg_free;

   assign oreg_free = !ovld_q || aes_if.out_ready;
`endif

   assign last_round = (round_q >= 4'(AES_NR));

   aes_round_dp u_dp (
      .state_i (blk_q),
      .rk_i    (aes_if.rk_data),
      .last_i  (last_round),
      .state_o (dp_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         blk_q   <= '0;
`ifdef AES_OUT_REG_EN
         oreg_q  <= '0;
         ovld_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         blk_q   <= blk_d;
`ifdef AES_OUT_REG_EN
         oreg_q  <= oreg_d;
         ovld_q  <= ovld_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      blk_d   = blk_q;
`ifdef AES_OUT_REG_EN
      oreg_d  = oreg_q;
      ovld_d  = ovld_q && !aes_if.out_ready;
`endif
      case (state_q)
         ST_IDLE: begin
            if (aes_if.in_valid) begin
               blk_d   = aes_if.in_data ^ aes_if.rk_data;
               round_d = 4'd1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            blk_d = dp_out;
            if (!last_round) begin
               round_d = round_q + 4'd1;
            end else begin
`ifdef AES_OUT_REG_EN
               if (oreg_free) begin
                  oreg_d  = dp_out;
                  ovld_d  = 1'b1;
                  round_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef AES_OUT_REG_EN
         ST_HOLD: begin
            if (oreg_free) begin
               oreg_d  = blk_q;
               ovld_d  = 1'b1;
               round_d = '0;
               state_d = ST_IDLE;
            end
         end
`else
         ST_DONE: begin
            if (aes_if.out_ready) begin
               round_d = '0;
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            round_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // rk_idx comes from registered state only, never from in_valid.
   always_comb begin
      aes_if.in_ready = 1'b0;
      aes_if.rk_idx   = '0;
      aes_if.round    = '0;
      aes_if.busy     = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: aes_if.in_ready = rst_n;
         ST_RUN: begin
            aes_if.rk_idx = round_q;
            aes_if.round  = round_q;
         end
         ST_HOLD: aes_if.rk_idx = 4'(AES_NR);
         default: ;
      endcase
`ifdef AES_OUT_REG_EN
      aes_if.out_valid = ovld_q;
      aes_if.out_data  = oreg_q;
`else
      aes_if.out_valid = (state_q == ST_DONE);
      aes_if.out_data  = blk_q;
`endif
   end

endmodule
